// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkg
// Purpose  : Shared NoC link constants and sender state type.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int PL_DEFAULT      = 8;
    localparam int CREDITS_DEFAULT = 4;

    localparam logic [PL_DEFAULT-1:0] EMPTY_FLIT = '0;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sender_state_t;

endpackage
`default_nettype wire

// File: rtl/queue_link_sender_if.sv
`default_nettype none
// ============================================================================
// Module   : queue_link_sender_if
// Purpose  : Queue-side and link-side signals of the link sender.
// Revision : 1.0 - initial release
// ============================================================================
interface queue_link_sender_if
    import noc_pkg::*;
#(
    parameter int PL = PL_DEFAULT
);
    logic [PL-1:0] queue_data;
    logic          queue_shift;
    logic          flush;
    logic [PL-1:0] link_data;
    logic          link_valid;
    logic          credit_return;

    modport master (
        input  queue_data,
        input  flush,
        input  credit_return,
        output queue_shift,
        output link_data,
        output link_valid
    );

    modport slave (
        output queue_data,
        output flush,
        output credit_return,
        input  queue_shift,
        input  link_data,
        input  link_valid
    );
endinterface
`default_nettype wire

// File: rtl/queue_link_sender_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : credit_counter
// Purpose  : Saturating credit counter with sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module credit_counter
    import noc_pkg::*;
#(
    parameter int CREDITS = CREDITS_DEFAULT,
    parameter int CW      = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          inc,
    input  wire logic          dec,
    output logic      [CW-1:0] count,
    output logic               overflow
);
    logic [CW-1:0] r_count;
    logic          r_overflow;

    // Simultaneous inc and dec cancel; an inc at full scale is an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= CW'(CREDITS);
            r_overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (r_count == CW'(CREDITS)) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign count    = r_count;
    assign overflow = r_overflow;
endmodule
`default_nettype wire

// File: rtl/queue_link_sender.sv
`default_nettype none
// ============================================================================
// Module   : queue_link_sender
// Purpose  : Pops queue head flits onto a credit flow-controlled link.
// Revision : 1.0 - initial release
// ============================================================================
module queue_link_sender
    import noc_pkg::*;
#(
    parameter int PL        = PL_DEFAULT,
    parameter int CREDITS   = CREDITS_DEFAULT,
    parameter int CW        = 3,
    parameter int STALL_CYC = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    queue_link_sender_if.master bus,
    output logic       [CW-1:0] credit_count,
    output logic                link_stall,
    output logic                credit_err,
    output logic       [15:0]   sent_count
);
    localparam int TW = $clog2(STALL_CYC + 1);

    sender_state_t r_state;
    sender_state_t w_next_state;

    logic          w_head;
    logic          w_send;
    logic          w_shift;
    logic          w_starve;
    logic [PL-1:0] r_link_data;
    logic          r_link_valid;
    logic [15:0]   r_sent_count;
    logic [TW-1:0] r_timer;
    logic          r_link_stall;
    logic [CW-1:0] w_credit_count;
    logic          w_credit_err;

    assign w_head   = (bus.queue_data != PL'(EMPTY_FLIT));
    assign w_starve = (r_state == RUN) && w_head && (w_credit_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_send       = 1'b0;
        w_shift      = 1'b0;
        unique case (r_state)
            RUN: begin
                w_send  = w_head && (w_credit_count != '0);
                w_shift = w_send;
                if (bus.flush) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                w_shift = w_head;
                if (!bus.flush) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    assign bus.queue_shift = w_shift & ~rst;

    // The link idles at zero whenever nothing is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_link_data  <= '0;
            r_link_valid <= 1'b0;
            r_sent_count <= '0;
        end else begin
            r_link_valid <= w_send;
            r_link_data  <= w_send ? bus.queue_data : '0;
            if (w_send) begin
                r_sent_count <= r_sent_count + 16'd1;
            end
        end
    end

    // Stall asserts on the same edge the timer reaches STALL_CYC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer      <= '0;
            r_link_stall <= 1'b0;
        end else if (w_starve) begin
            if (r_timer != TW'(STALL_CYC)) begin
                r_timer <= r_timer + TW'(1);
            end
            r_link_stall <= (r_timer >= TW'(STALL_CYC - 1));
        end else begin
            r_timer      <= '0;
            r_link_stall <= 1'b0;
        end
    end

    credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_credit_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (bus.credit_return),
        .dec      (w_send),
        .count    (w_credit_count),
        .overflow (w_credit_err)
    );

    assign bus.link_data  = r_link_data;
    assign bus.link_valid = r_link_valid;
    assign credit_count   = w_credit_count;
    assign credit_err     = w_credit_err;
    assign link_stall     = r_link_stall;
    assign sent_count     = r_sent_count;
endmodule
`default_nettype wire

// File: tb/tb_queue_link_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_queue_link_sender
// Purpose  : Self-checking bench for queue_link_sender against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_queue_link_sender;
    localparam int CREDITS = 4;
    localparam int STALL   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  credit_count;
    logic        link_stall;
    logic        credit_err;
    logic [15:0] sent_count;

    queue_link_sender_if #(.PL(8)) bif ();

    queue_link_sender #(
        .PL        (8),
        .CREDITS   (CREDITS),
        .CW        (3),
        .STALL_CYC (STALL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bif),
        .credit_count (credit_count),
        .link_stall   (link_stall),
        .credit_err   (credit_err),
        .sent_count   (sent_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] fifo[$];
    int         m_cred;
    int         m_sent;
    int         m_timer;
    bit         m_err;
    bit         m_flush;
    bit         m_valid;
    bit         m_stall;
    logic [7:0] m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cred = CREDITS; m_sent = 0; m_timer = 0; m_err = 0;
        m_flush = 0; m_valid = 0; m_stall = 0; m_data = 8'h00;
    endtask

    task automatic check_outputs();
        chk("link_valid",   32'(bif.link_valid), 32'(m_valid));
        chk("link_data",    32'(bif.link_data),  32'(m_data));
        chk("credit_count", 32'(credit_count),   32'(m_cred));
        chk("link_stall",   32'(link_stall),     32'(m_stall));
        chk("credit_err",   32'(credit_err),     32'(m_err));
        chk("sent_count",   32'(sent_count),     32'(m_sent));
    endtask

    // One clock: drive at negedge, check pop request, advance model at posedge.
    task automatic cycle(input bit fl, input bit cr);
        logic [7:0] head;
        bit hv, send, shift, starve;
        @(negedge clk);
        head = (fifo.size() != 0) ? fifo[0] : 8'h00;
        bif.queue_data    = head;
        bif.flush         = fl;
        bif.credit_return = cr;
        hv     = (head != 8'h00);
        send   = !m_flush && hv && (m_cred > 0);
        shift  = m_flush ? hv : send;
        starve = !m_flush && hv && (m_cred == 0);
        #1 chk("queue_shift", 32'(bif.queue_shift), 32'(shift));
        @(posedge clk);
        if (shift) void'(fifo.pop_front());
        m_valid = send;
        m_data  = send ? head : 8'h00;
        if (send) m_sent = (m_sent + 1) % 65536;
        if (cr && !send && m_cred == CREDITS) m_err = 1;
        else m_cred = m_cred + int'(cr) - int'(send);
        m_timer = starve ? ((m_timer < STALL) ? m_timer + 1 : STALL) : 0;
        m_stall = (m_timer >= STALL);
        m_flush = fl;
        #1 check_outputs();
    endtask

    initial begin
        bit fl;
        bif.queue_data = 8'h00; bif.flush = 1'b0; bif.credit_return = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk("reset_credits", 32'(credit_count), 32'd4);
        chk("reset_valid", 32'(bif.link_valid), 32'd0);
        chk("reset_shift", 32'(bif.queue_shift), 32'd0);
        check_outputs();
        @(negedge clk); rst = 1'b0;

        // Burst of four consumes every credit.
        for (int i = 0; i < 4; i++) fifo.push_back(8'h81 + 8'(i));
        cycle(0, 0);
        chk("burst_first_data", 32'(bif.link_data), 32'h81);
        for (int i = 0; i < 3; i++) cycle(0, 0);
        chk("burst_last_data", 32'(bif.link_data), 32'h84);
        chk("burst_credits", 32'(credit_count), 32'd0);
        chk("burst_sent", 32'(sent_count), 32'd4);

        // Starved head: stall appears on the 16th cycle.
        fifo.push_back(8'h85);
        for (int i = 0; i < 15; i++) cycle(0, 0);
        chk("stall_before", 32'(link_stall), 32'd0);
        cycle(0, 0);
        chk("stall_at_16", 32'(link_stall), 32'd1);
        for (int i = 0; i < 4; i++) cycle(0, 0);
        cycle(0, 1);
        chk("stall_credit_back", 32'(credit_count), 32'd1);
        cycle(0, 0);
        chk("stall_send_data", 32'(bif.link_data), 32'h85);
        chk("stall_cleared", 32'(link_stall), 32'd0);
        chk("stall_credits", 32'(credit_count), 32'd0);

        // Send and return together leave the count unchanged.
        cycle(0, 1); cycle(0, 1);
        fifo.push_back(8'h90);
        cycle(0, 1);
        chk("sendret_credits", 32'(credit_count), 32'd2);
        chk("sendret_data", 32'(bif.link_data), 32'h90);

        // Return at full scale sets the sticky error.
        cycle(0, 1); cycle(0, 1); cycle(0, 1);
        chk("over_credits", 32'(credit_count), 32'd4);
        chk("over_err", 32'(credit_err), 32'd1);
        fifo.push_back(8'h91);
        cycle(0, 0); cycle(0, 1);
        chk("over_err_sticky", 32'(credit_err), 32'd1);

        // Flush discards without sending or spending credits.
        cycle(1, 0);
        for (int i = 0; i < 4; i++) fifo.push_back(8'h86 + 8'(i));
        for (int i = 0; i < 4; i++) cycle(1, 0);
        chk("flush_sent", 32'(sent_count), 32'd7);
        chk("flush_credits", 32'(credit_count), 32'd4);
        chk("flush_drained", 32'(fifo.size()), 32'd0);
        cycle(0, 0);
        fifo.push_back(8'h8A);
        cycle(0, 0);
        chk("after_flush_data", 32'(bif.link_data), 32'h8A);
        chk("after_flush_sent", 32'(sent_count), 32'd8);

        // Reset in the middle of a burst at one credit left.
        for (int i = 0; i < 4; i++) fifo.push_back(8'hA0 + 8'(i));
        cycle(0, 0); cycle(0, 0);
        chk("pre_rst_credits", 32'(credit_count), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(bif.link_valid), 32'd0);
        chk("rst_data", 32'(bif.link_data), 32'd0);
        chk("rst_credits", 32'(credit_count), 32'd4);
        chk("rst_sent", 32'(sent_count), 32'd0);
        chk("rst_err", 32'(credit_err), 32'd0);
        chk("rst_shift", 32'(bif.queue_shift), 32'd0);
        @(negedge clk);
        bif.queue_data = 8'h00; bif.flush = 1'b0; bif.credit_return = 1'b0;
        rst = 1'b0;

        // Randomized traffic against the queue model.
        fl = 0;
        for (int i = 0; i < 2000; i++) begin
            if (fifo.size() < 6 && ($urandom % 3) != 0)
                fifo.push_back(8'($urandom_range(1, 255)));
            if (($urandom % 25) == 0) fl = ~fl;
            cycle(fl, ($urandom % 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
